// File: rtl/ddr2_bridge_pkg.sv
// rtl/ddr2_bridge_pkg.sv - shared types and constants for the cache-to-MIG line bridge
package ddr2_bridge_pkg;

   localparam int LINE_W = 128;

   localparam logic [2:0] APP_CMD_WRITE = 3'b000;
   localparam logic [2:0] APP_CMD_READ  = 3'b001;

   typedef enum logic [1:0] {
      IDLE,
      WR,
      RD_CMD,
      RD_WAIT
   } state_t;

endpackage

// File: rtl/ddr2_rd_watchdog.sv
// rtl/ddr2_rd_watchdog.sv - read-wait cycle counter; fires on the RD_TIMEOUT-th enabled cycle
module ddr2_rd_watchdog #(
   parameter int RD_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic fire
);

   localparam int CW = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (enable && !fire) begin
         cnt <= cnt + CW'(1);
      end
   end

   // A zero timeout means the watchdog never fires.
   generate
      if (RD_TIMEOUT == 0) begin : g_off
         assign fire = 1'b0;
      end else begin : g_on
         assign fire = enable && (cnt == CW'(RD_TIMEOUT - 1));
      end
   endgenerate

endmodule

// File: rtl/ddr2_mig_bridge.sv
// rtl/ddr2_mig_bridge.sv - cache line port to MIG app_* bridge, one request in flight
// Define DDR2_BRIDGE_WRACK_EN to also pulse ddr2_available on write completion.
module ddr2_mig_bridge
   import ddr2_bridge_pkg::*;
#(
   parameter int APP_ADDR_SHIFT = 1,
   parameter int RD_TIMEOUT     = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [26:0]       ddr2_addr,
   input  logic              ddr2_enable,
   input  logic              ddr2_read,
   input  logic [LINE_W-1:0] to_ddr2_data,
   output logic [LINE_W-1:0] ddr2_data,
   output logic              ddr2_available,
   output logic              ddr2_busy,
   output logic              req_dropped,
   output logic              rd_timeout,
   output logic [26:0]       app_addr,
   output logic [2:0]        app_cmd,
   output logic              app_en,
   input  logic              app_rdy,
   output logic [LINE_W-1:0] app_wdf_data,
   output logic              app_wdf_wren,
   output logic              app_wdf_end,
   output logic [15:0]       app_wdf_mask,
   input  logic              app_wdf_rdy,
   input  logic [LINE_W-1:0] app_rd_data,
   input  logic              app_rd_data_valid,
   input  logic              init_calib_complete
);

   state_t      state, state_nxt;
   logic        cmd_done, wdf_done;
   logic        cmd_hs, wdf_hs;
   logic        capture, wr_exit, rd_done, wd_fire;
   logic [26:0] line_addr;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^ddr2_addr[3:0];
   assign line_addr        = {ddr2_addr[26:4], 4'b0000};

   // The completion-pulse cycle counts as busy so a new request cannot overlap it.
   assign ddr2_busy = (state != IDLE) || !init_calib_complete || ddr2_available;
   assign capture   = ddr2_enable && !ddr2_busy;

   assign app_en       = init_calib_complete &&
                         (((state == WR) && !cmd_done) || (state == RD_CMD));
   assign app_wdf_wren = (state == WR) && !wdf_done;
   assign app_wdf_end  = app_wdf_wren;
   assign app_wdf_mask = 16'h0000;

   assign cmd_hs  = app_en && app_rdy;
   assign wdf_hs  = app_wdf_wren && app_wdf_rdy;
   assign wr_exit = (state == WR) && (cmd_done || cmd_hs) && (wdf_done || wdf_hs);
   assign rd_done = (state == RD_WAIT) && app_rd_data_valid;

   ddr2_rd_watchdog #(
      .RD_TIMEOUT (RD_TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (state != RD_WAIT),
      .enable (state == RD_WAIT),
      .fire   (wd_fire)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (capture) state_nxt = ddr2_read ? RD_CMD : WR;
         WR:      if (wr_exit) state_nxt = IDLE;
         RD_CMD:  if (cmd_hs) state_nxt = RD_WAIT;
         RD_WAIT: if (app_rd_data_valid || wd_fire) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         cmd_done       <= 1'b0;
         wdf_done       <= 1'b0;
         app_addr       <= '0;
         app_cmd        <= APP_CMD_WRITE;
         app_wdf_data   <= '0;
         ddr2_data      <= '0;
         ddr2_available <= 1'b0;
         req_dropped    <= 1'b0;
         rd_timeout     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            app_addr     <= line_addr >> APP_ADDR_SHIFT;
            app_cmd      <= ddr2_read ? APP_CMD_READ : APP_CMD_WRITE;
            app_wdf_data <= to_ddr2_data;
            cmd_done     <= 1'b0;
            wdf_done     <= 1'b0;
         end else if (state == WR) begin
            if (cmd_hs) cmd_done <= 1'b1;
            if (wdf_hs) wdf_done <= 1'b1;
         end
         if (rd_done) ddr2_data <= app_rd_data;
`ifdef DDR2_BRIDGE_WRACK_EN
         ddr2_available <= rd_done || wr_exit;
`else
         ddr2_available <= rd_done;
`endif
         if (ddr2_enable && ddr2_busy) req_dropped <= 1'b1;
         // Data arriving on the watchdog's last cycle still wins.
         if ((state == RD_WAIT) && wd_fire && !app_rd_data_valid) rd_timeout <= 1'b1;
      end
   end

endmodule
